// File: rtl/mux4_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the 4-channel round-robin mux arbiter:
//   - arb_state_t   : arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   - NUM_CH        : number of requesting channels (4)
//   - onehot_to_idx : binary index of the set bit in a one-hot grant vector
// -----------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // OR-encodes the set bit positions. The result is only meaningful for a
    // one-hot input; an all-zero input yields 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                idx = idx | 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// -----------------------------------------------------------------------------
// mux4_sel
// Purely combinational DATA_W-wide 4:1 multiplexer. The arbiter top level
// registers the output.
//
// Ports:
//   i_sel    in  2       binary channel select
//   i_din0-3 in  DATA_W  channel data
//   o_dout   out DATA_W  selected channel data
// -----------------------------------------------------------------------------
module mux4_sel #(
    parameter int DATA_W = 1
) (
    input  logic [1:0]        i_sel,
    input  logic [DATA_W-1:0] i_din0,
    input  logic [DATA_W-1:0] i_din1,
    input  logic [DATA_W-1:0] i_din2,
    input  logic [DATA_W-1:0] i_din3,
    output logic [DATA_W-1:0] o_dout
);

    always_comb begin
        // NOTE: o_dout is assigned on every path (full case plus default), so
        // no latch is inferred.
        o_dout = '0;
        unique case (i_sel)
            2'd0:    o_dout = i_din0;
            2'd1:    o_dout = i_din1;
            2'd2:    o_dout = i_din2;
            2'd3:    o_dout = i_din3;
            default: o_dout = '0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin controller for a shared 4:1 mux. Arbitrates four level-sensitive
// requests, drives a registered one-hot grant and binary select, and registers
// the selected channel data onto dout one cycle after the grant.
//
// Configuration macro:
//   MUX4_ARB_HOLD_LIMIT_EN - when defined, an owner is forced to hand over
//                            after MAX_HOLD consecutive cycles if another
//                            channel is waiting. When undefined, arbitration
//                            is non-preemptive and MAX_HOLD is ignored.
//
// Ports:
//   clk        in  1       rising-edge clock
//   rst_n      in  1       synchronous active-low reset
//   req        in  4       per-channel request, level-sensitive
//   din0-din3  in  DATA_W  channel data
//   grant      out 4       one-hot owner, registered; 0 = no owner
//   sel        out 2       binary owner index, registered; holds in IDLE
//   busy       out 1       high while in GRANT state
//   dout       out DATA_W  registered mux output
//   dout_valid out 1       dout carries owner data
// -----------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req,
    input  logic [DATA_W-1:0]   din0,
    input  logic [DATA_W-1:0]   din1,
    input  logic [DATA_W-1:0]   din2,
    input  logic [DATA_W-1:0]   din3,
    output logic [NUM_CH-1:0]   grant,
    output logic [1:0]          sel,
    output logic                busy,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid
);

    arb_state_t          r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_grant, w_grant_nxt;
    logic [1:0]          r_sel,   w_sel_nxt;
    logic [1:0]          r_ptr,   w_ptr_nxt;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;
    logic [DATA_W-1:0]   w_mux_out;

    logic [NUM_CH-1:0]   w_cand;        // channels eligible to become owner
    logic                w_found;       // some eligible channel is requesting
    logic [1:0]          w_pick;        // first eligible channel from r_ptr
    logic                w_owner_req;   // current owner still requesting
    logic                w_change;      // owner changes at this edge

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
`else
    logic                w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD > 0);
`endif

    // While granted, the owner is masked out so a search finds the *next*
    // requester; r_ptr is already owner+1, so the search starts right after it.
    assign w_cand      = (r_state == ARB_GRANT) ? (req & ~r_grant) : req;
    assign w_owner_req = |(req & r_grant);

    // Priority search in rotating order r_ptr, r_ptr+1, ... (2-bit wrap).
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && w_cand[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_pick  = r_ptr + 2'(i);
            end
        end
    end

    // Next-state / next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_change    = 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        w_hold_nxt  = r_hold_cnt;
`endif

        unique case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_change = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!w_owner_req) begin
                    if (w_found) begin
                        w_change = 1'b1;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                    end
                end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                else if (r_hold_cnt == HOLD_LAST && w_found) begin
                    w_change = 1'b1;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase

        if (w_change) begin
            w_state_nxt = ARB_GRANT;
            w_grant_nxt = NUM_CH'(1) << w_pick;
            w_ptr_nxt   = w_pick + 2'd1;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            w_hold_nxt  = '0;
`endif
        end
    end

    // sel tracks the grant bit and keeps its last value while no one owns.
    assign w_sel_nxt = (w_grant_nxt != '0) ? onehot_to_idx(w_grant_nxt) : r_sel;

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_mux (
        .i_sel  (r_sel),
        .i_din0 (din0),
        .i_din1 (din1),
        .i_din2 (din2),
        .i_din3 (din3),
        .o_dout (w_mux_out)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_sel        <= '0;
            r_ptr        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            r_hold_cnt   <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_sel        <= w_sel_nxt;
            r_ptr        <= w_ptr_nxt;
            // Data path lags the grant by one cycle: it captures the channel
            // selected by the grant that is already on the outputs.
            r_dout       <= (|r_grant) ? w_mux_out : '0;
            r_dout_valid <= |r_grant;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            r_hold_cnt   <= w_hold_nxt;
`endif
        end
    end

    assign grant      = r_grant;
    assign sel        = r_sel;
    assign busy       = (r_state == ARB_GRANT);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Scoreboard bench: the stimulus process drives inputs on the falling edge,
// advances a behavioural model of the arbitration rules and queues the
// expected post-edge outputs; a monitor process pops and compares them just
// after every rising edge.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    localparam int DW       = 4;
    localparam int MAX_HOLD = 4;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_ON  = 1'b1;
`else
    localparam bit HOLD_ON  = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]    grant;
        logic [1:0]    sel;
        logic          busy;
        logic [DW-1:0] dout;
        logic          dv;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din0, din1, din2, din3;
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic          busy;
    logic [DW-1:0] dout;
    logic          dout_valid;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(
        .DATA_W   (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .grant      (grant),
        .sel        (sel),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: owner index (-1 = none), priority pointer,
    // consecutive-hold count, last select and the registered data outputs.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_hold  = 0;
    int            m_sel   = 0;
    logic [DW-1:0] m_dout  = '0;
    logic          m_dv    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // First requesting channel when scanning p, p+1, p+2, p+3 (mod 4).
    function automatic int first_from(input logic [3:0] c, input int p);
        for (int k = 0; k < 4; k++) begin
            if (c[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Apply one cycle of stimulus and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [3:0] q);
        logic [DW-1:0] d [4];
        logic [3:0]    others;
        int            nxt;
        bit            change;
        exp_t          e;

        @(negedge clk);
        for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
        rst_n = r;
        req   = q;
        din0  = d[0];
        din1  = d[1];
        din2  = d[2];
        din3  = d[3];

        if (!r) begin
            m_owner = -1;
            m_sel   = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_dout  = '0;
            m_dv    = 1'b0;
        end else begin
            // Data registered this edge comes from the owner visible before it.
            m_dout = (m_owner >= 0) ? d[m_sel] : '0;
            m_dv   = (m_owner >= 0);

            change = 1'b0;
            nxt    = m_owner;
            if (m_owner < 0) begin
                nxt    = first_from(q, m_ptr);
                change = (nxt >= 0);
            end else begin
                others          = q;
                others[m_owner] = 1'b0;
                if (!q[m_owner]) begin
                    nxt    = first_from(others, m_ptr);
                    change = (nxt >= 0);
                end else if (HOLD_ON && m_hold == MAX_HOLD - 1 && others != 4'b0) begin
                    nxt    = first_from(others, m_ptr);
                    change = 1'b1;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
            end
            m_owner = nxt;
            if (change) begin
                m_sel  = nxt;
                m_ptr  = (nxt + 1) % 4;
                m_hold = 0;
            end
        end

        e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        e.sel   = 2'(m_sel);
        e.busy  = (m_owner >= 0);
        e.dout  = m_dout;
        e.dv    = m_dv;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every rising edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",      32'(grant),      32'(e.grant));
                check("sel",        32'(sel),        32'(e.sel));
                check("busy",       32'(busy),       32'(e.busy));
                check("dout",       32'(dout),       32'(e.dout));
                check("dout_valid", 32'(dout_valid), 32'(e.dv));
            end
        end
    end

    // Stimulus.
    initial begin
        logic [3:0] q;
        logic       r;

        rst_n = 1'b0;
        req   = 4'b0;
        din0  = '0;
        din1  = '0;
        din2  = '0;
        din3  = '0;

        // Reset held with all channels requesting, then release.
        repeat (3)  step(1'b0, 4'b1111);
        repeat (18) step(1'b1, 4'b1111);

        // Single requester holds the grant indefinitely.
        step(1'b0, 4'b0000);
        repeat (22) step(1'b1, 4'b0100);

        // Drop handoffs: 2 -> 1, then 1 -> 3 with no idle cycle, then idle.
        repeat (3) step(1'b1, 4'b0010);
        repeat (2) step(1'b1, 4'b1010);
        repeat (2) step(1'b1, 4'b1000);
        repeat (3) step(1'b1, 4'b0000);

        // Two requesters held; owner 0 releases.
        repeat (10) step(1'b1, 4'b0011);
        repeat (3)  step(1'b1, 4'b0010);

        // Mid-grant reset with owner 3, then 0 and 3 compete.
        repeat (3) step(1'b1, 4'b1000);
        step(1'b0, 4'b1001);
        repeat (3) step(1'b1, 4'b1001);

        // Randomised traffic with sticky requests and occasional resets.
        q = 4'b1111;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                q = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom);
            end
            r = ($urandom_range(0, 63) != 0);
            step(r, q);
        end
        repeat (2) step(1'b1, 4'b0000);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog: the run is bounded even if the clock or a process stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
